led_adc_sequencer: RTL and testbench

Upstream stage of the red/IR FIR filters in the pulse-oximeter datapath. Alternates the finger-clip LEDs between red and infrared at a 100 Hz full period (5 ms per LED). In each LED phase it waits for optical settling, runs one handshaked 8-bit ADC conversion, and publishes the result as RED_ADC_Value or IR_ADC_Value with a one-cycle valid strobe. The strobe is the sample tick for the matching filter.

---
 rtl/oxi_pkg.sv | 37 +++
 rtl/led_adc_sequencer_sample_capture.sv | 52 +++++
 rtl/led_adc_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_led_adc_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oxi_pkg.sv
// Shared definitions for the pulse-oximeter datapath.
//
// Holds the LED/ADC sequencer state encoding and the default timing
// constants used by the sequencer, the red/IR FIR filters and the display
// stage. All defaults assume a 10 MHz system clock.
//
// Contents:
//   DEF_HALF_PERIOD_CYC  cycles per LED phase (5 ms)
//   DEF_SETTLE_CYC       optical settling time before a conversion
//   DEF_ADC_TIMEOUT_CYC  longest allowed adc_start -> adc_done wait
//   DEF_CNT_W            width of the phase counter
//   ADC_W                ADC sample width
//   seq_state_e          sequencer state encoding
//   is_red_state()       true for the three red-phase states
package oxi_pkg;

    localparam int unsigned DEF_HALF_PERIOD_CYC = 50000;
    localparam int unsigned DEF_SETTLE_CYC      = 10000;
    localparam int unsigned DEF_ADC_TIMEOUT_CYC = 255;
    localparam int unsigned DEF_CNT_W           = 16;
    localparam int unsigned ADC_W               = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RED_SETTLE = 3'd1,
        ST_RED_CONV   = 3'd2,
        ST_RED_HOLD   = 3'd3,
        ST_IR_SETTLE  = 3'd4,
        ST_IR_CONV    = 3'd5,
        ST_IR_HOLD    = 3'd6
    } seq_state_e;

    function automatic logic is_red_state(input seq_state_e s);
        return (s == ST_RED_SETTLE) || (s == ST_RED_CONV) || (s == ST_RED_HOLD);
    endfunction

endpackage

// File: rtl/led_adc_sequencer_sample_capture.sv
// sample_capture: holding register for one ADC channel plus its sample strobe.
//
// When load_i is high the value on data_i is stored and valid_o pulses high
// for exactly the following cycle, i.e. value_o and valid_o change together
// one clock after the load request.
//
// Ports:
//   clk_i    system clock
//   rst_ni   synchronous reset, active low (clears value and strobe)
//   load_i   capture request (one cycle)
//   data_i   sample to capture
//   value_o  last captured sample
//   valid_o  one-cycle strobe marking a fresh value_o
module sample_capture
    import oxi_pkg::*;
#(
    parameter int unsigned W = ADC_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] value_o,
    output logic         valid_o
);

    logic [W-1:0] value_q, value_d;
    logic         valid_q, valid_d;

    always_comb begin
        value_d = value_q;
        valid_d = 1'b0;
        if (load_i) begin
            value_d = data_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            value_q <= '0;
            valid_q <= 1'b0;
        end else begin
            value_q <= value_d;
            valid_q <= valid_d;
        end
    end

    assign value_o = value_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/led_adc_sequencer.sv
// led_adc_sequencer: red/IR LED alternation and ADC sampling for the
// pulse-oximeter front end.
//
// Each LED phase lasts HALF_PERIOD_CYC cycles. After SETTLE_CYC cycles of
// optical settling one handshaked conversion is issued; the result is
// published on RED_ADC_Value / IR_ADC_Value with a one-cycle valid strobe
// that serves as the sample tick of the matching FIR filter.
//
// Ports:
//   CLK            system clock
//   rst_n          synchronous reset, active low
//   enable         run request, sampled in IDLE and at phase ends only
//   adc_start      one-cycle conversion request
//   adc_done       one-cycle conversion-complete pulse
//   adc_data       conversion result, valid with adc_done
//   LED_RED_on     red LED drive
//   LED_IR_on      IR LED drive
//   RED_ADC_Value  last good red sample
//   IR_ADC_Value   last good IR sample
//   red_valid      strobe: RED_ADC_Value updated this cycle
//   ir_valid       strobe: IR_ADC_Value updated this cycle
//   adc_timeout    sticky conversion-abort flag, cleared by reset only
module led_adc_sequencer
    import oxi_pkg::*;
#(
    parameter int unsigned HALF_PERIOD_CYC = DEF_HALF_PERIOD_CYC,
    parameter int unsigned SETTLE_CYC      = DEF_SETTLE_CYC,
    parameter int unsigned ADC_TIMEOUT_CYC = DEF_ADC_TIMEOUT_CYC,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             enable,
    output logic             adc_start,
    input  logic             adc_done,
    input  logic [ADC_W-1:0] adc_data,
    output logic             LED_RED_on,
    output logic             LED_IR_on,
    output logic [ADC_W-1:0] RED_ADC_Value,
    output logic [ADC_W-1:0] IR_ADC_Value,
    output logic             red_valid,
    output logic             ir_valid,
    output logic             adc_timeout
);

    localparam int unsigned CONV_W = (ADC_TIMEOUT_CYC > 1) ? $clog2(ADC_TIMEOUT_CYC + 1) : 1;

    localparam logic [CNT_W-1:0]  PHASE_LAST  = CNT_W'(HALF_PERIOD_CYC - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CONV_W-1:0] CONV_LAST   = CONV_W'(ADC_TIMEOUT_CYC - 1);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  phase_cnt_q, phase_cnt_d;
    logic [CONV_W-1:0] conv_cnt_q, conv_cnt_d;
    logic              led_red_q, led_red_d;
    logic              led_ir_q, led_ir_d;
    logic              adc_start_q, adc_start_d;
    logic              timeout_q, timeout_d;

    logic              phase_end;
    logic              load_red;
    logic              load_ir;

    assign phase_end = (state_q != ST_IDLE) && (phase_cnt_q == PHASE_LAST);

    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        conv_cnt_d  = '0;
        led_red_d   = led_red_q;
        led_ir_d    = led_ir_q;
        adc_start_d = 1'b0;
        timeout_d   = timeout_q;
        load_red    = 1'b0;
        load_ir     = 1'b0;

        if (state_q != ST_IDLE) begin
            phase_cnt_d = phase_end ? '0 : phase_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d     = ST_RED_SETTLE;
                    led_red_d   = 1'b1;
                    led_ir_d    = 1'b0;
                    phase_cnt_d = '0;
                end
            end
            ST_RED_SETTLE: begin
                if (phase_cnt_q == SETTLE_LAST) begin
                    state_d     = ST_RED_CONV;
                    adc_start_d = 1'b1;
                end
            end
            ST_RED_CONV: begin
                conv_cnt_d = conv_cnt_q + CONV_W'(1);
                if (adc_done) begin
                    load_red = 1'b1;
                    state_d  = ST_RED_HOLD;
                end else if (conv_cnt_q == CONV_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_RED_HOLD;
                end
            end
            ST_RED_HOLD: begin
                state_d = ST_RED_HOLD;
            end
            ST_IR_SETTLE: begin
                if (phase_cnt_q == SETTLE_LAST) begin
                    state_d     = ST_IR_CONV;
                    adc_start_d = 1'b1;
                end
            end
            ST_IR_CONV: begin
                conv_cnt_d = conv_cnt_q + CONV_W'(1);
                if (adc_done) begin
                    load_ir = 1'b1;
                    state_d = ST_IR_HOLD;
                end else if (conv_cnt_q == CONV_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IR_HOLD;
                end
            end
            ST_IR_HOLD: begin
                state_d = ST_IR_HOLD;
            end
            default: begin
                state_d   = ST_IDLE;
                led_red_d = 1'b0;
                led_ir_d  = 1'b0;
            end
        endcase

        // The phase end overrides whatever the per-state logic chose. A done
        // arriving on this cycle was already captured above; a conversion
        // still open without done is abandoned and flagged.
        if (phase_end) begin
            if (((state_q == ST_RED_CONV) || (state_q == ST_IR_CONV)) && !adc_done) begin
                timeout_d = 1'b1;
            end
            conv_cnt_d  = '0;
            adc_start_d = 1'b0;
            if (!enable) begin
                state_d   = ST_IDLE;
                led_red_d = 1'b0;
                led_ir_d  = 1'b0;
            end else if (is_red_state(state_q)) begin
                state_d   = ST_IR_SETTLE;
                led_red_d = 1'b0;
                led_ir_d  = 1'b1;
            end else begin
                state_d   = ST_RED_SETTLE;
                led_red_d = 1'b1;
                led_ir_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_cnt_q <= '0;
            conv_cnt_q  <= '0;
            led_red_q   <= 1'b0;
            led_ir_q    <= 1'b0;
            adc_start_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            conv_cnt_q  <= conv_cnt_d;
            led_red_q   <= led_red_d;
            led_ir_q    <= led_ir_d;
            adc_start_q <= adc_start_d;
            timeout_q   <= timeout_d;
        end
    end

    sample_capture #(
        .W(ADC_W)
    ) u_red_capture (
        .clk_i  (CLK),
        .rst_ni (rst_n),
        .load_i (load_red),
        .data_i (adc_data),
        .value_o(RED_ADC_Value),
        .valid_o(red_valid)
    );

    sample_capture #(
        .W(ADC_W)
    ) u_ir_capture (
        .clk_i  (CLK),
        .rst_ni (rst_n),
        .load_i (load_ir),
        .data_i (adc_data),
        .value_o(IR_ADC_Value),
        .valid_o(ir_valid)
    );

    assign adc_start   = adc_start_q;
    assign LED_RED_on  = led_red_q;
    assign LED_IR_on   = led_ir_q;
    assign adc_timeout = timeout_q;

endmodule

// File: tb/tb_led_adc_sequencer.sv
// Bench for led_adc_sequencer. Two instances share clock and reset:
//   dut_a  HALF=64, SETTLE=10, TIMEOUT=30  (legal timing, full sequencing)
//   dut_b  HALF=64, SETTLE=10, TIMEOUT=60  (conversion can reach phase end)
// Expected samples are queued by the stimulus; monitors pop them on every
// valid strobe and compare channel, value and cycle number.
module tb_led_adc_sequencer;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       enable_a, enable_b;
    logic       done_a, done_b;
    logic [7:0] data_a, data_b;

    logic       start_a, led_red_a, led_ir_a, red_valid_a, ir_valid_a, timeout_a;
    logic [7:0] red_val_a, ir_val_a;
    logic       start_b, led_red_b, led_ir_b, red_valid_b, ir_valid_b, timeout_b;
    logic [7:0] red_val_b, ir_val_b;

    always #5 CLK = ~CLK;

    led_adc_sequencer #(
        .HALF_PERIOD_CYC(64),
        .SETTLE_CYC     (10),
        .ADC_TIMEOUT_CYC(30),
        .CNT_W          (16)
    ) dut_a (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .enable       (enable_a),
        .adc_start    (start_a),
        .adc_done     (done_a),
        .adc_data     (data_a),
        .LED_RED_on   (led_red_a),
        .LED_IR_on    (led_ir_a),
        .RED_ADC_Value(red_val_a),
        .IR_ADC_Value (ir_val_a),
        .red_valid    (red_valid_a),
        .ir_valid     (ir_valid_a),
        .adc_timeout  (timeout_a)
    );

    led_adc_sequencer #(
        .HALF_PERIOD_CYC(64),
        .SETTLE_CYC     (10),
        .ADC_TIMEOUT_CYC(60),
        .CNT_W          (16)
    ) dut_b (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .enable       (enable_b),
        .adc_start    (start_b),
        .adc_done     (done_b),
        .adc_data     (data_b),
        .LED_RED_on   (led_red_b),
        .LED_IR_on    (led_ir_b),
        .RED_ADC_Value(red_val_b),
        .IR_ADC_Value (ir_val_b),
        .red_valid    (red_valid_b),
        .ir_valid     (ir_valid_b),
        .adc_timeout  (timeout_b)
    );

    logic [20:0] outs_a, outs_b;
    assign outs_a = {start_a, led_red_a, led_ir_a, red_val_a, ir_val_a, red_valid_a, ir_valid_a, timeout_a};
    assign outs_b = {start_b, led_red_b, led_ir_b, red_val_b, ir_val_b, red_valid_b, ir_valid_b, timeout_b};

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          ir;
        logic [7:0]  val;
        int unsigned cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    function automatic exp_t mk(input bit ir, input logic [7:0] val, input int unsigned c);
        exp_t e;
        e.ir  = ir;
        e.val = val;
        e.cyc = c;
        return e;
    endfunction

    // Drive point of cycle n (just after posedge n).
    task automatic goto(input int unsigned n);
        while (cyc < n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Sample point of cycle n (negedge inside cycle n).
    task automatic at(input int unsigned n);
        goto(n);
        @(negedge CLK);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic score_a(input bit ir, input logic [7:0] v);
        exp_t e;
        checks++;
        if (qa.size() == 0) begin
            failures++;
            $display("FAIL a_unexpected_valid cyc=%0d actual ir=%0b val=0x%0h expected=none", cyc, ir, v);
        end else begin
            e = qa.pop_front();
            if (e.ir != ir || e.val !== v || e.cyc != cyc) begin
                failures++;
                $display("FAIL a_sample actual ir=%0b val=0x%0h cyc=%0d expected ir=%0b val=0x%0h cyc=%0d",
                         ir, v, cyc, e.ir, e.val, e.cyc);
            end
        end
    endtask

    task automatic score_b(input bit ir, input logic [7:0] v);
        exp_t e;
        checks++;
        if (qb.size() == 0) begin
            failures++;
            $display("FAIL b_unexpected_valid cyc=%0d actual ir=%0b val=0x%0h expected=none", cyc, ir, v);
        end else begin
            e = qb.pop_front();
            if (e.ir != ir || e.val !== v || e.cyc != cyc) begin
                failures++;
                $display("FAIL b_sample actual ir=%0b val=0x%0h cyc=%0d expected ir=%0b val=0x%0h cyc=%0d",
                         ir, v, cyc, e.ir, e.val, e.cyc);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (red_valid_a === 1'b1) score_a(1'b0, red_val_a);
        if (ir_valid_a  === 1'b1) score_a(1'b1, ir_val_a);
        if (red_valid_b === 1'b1) score_b(1'b0, red_val_b);
        if (ir_valid_b  === 1'b1) score_b(1'b1, ir_val_b);
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1);
    end

    int unsigned c0, c1, cb0;
    bit          seen;

    initial begin
        rst_n    = 1'b0;
        enable_a = 1'b0;
        enable_b = 1'b0;
        done_a   = 1'b0;
        done_b   = 1'b0;
        data_a   = 8'h00;
        data_b   = 8'h00;

        // reset state
        at(3);
        chk("reset_outs_a", {11'b0, outs_a}, 32'h0);
        chk("reset_outs_b", {11'b0, outs_b}, 32'h0);
        goto(4);
        rst_n = 1'b1;
        at(5);
        chk("idle_leds_a", {30'b0, led_red_a, led_ir_a}, 32'h0);

        // nominal red/IR cycle
        goto(6);
        enable_a = 1'b1;
        c0 = 7;
        qa.push_back(mk(1'b0, 8'h5A, c0 + 31));
        qa.push_back(mk(1'b1, 8'hA5, c0 + 95));
        at(6);
        chk("led_red_before_enable", {31'b0, led_red_a}, 32'd0);
        at(c0);
        chk("led_red_rise", {30'b0, led_red_a, led_ir_a}, 32'b10);
        at(c0 + 9);
        chk("start_early", {31'b0, start_a}, 32'd0);
        at(c0 + 10);
        chk("start_at_settle", {31'b0, start_a}, 32'd1);
        at(c0 + 11);
        chk("start_one_cycle", {31'b0, start_a}, 32'd0);
        goto(c0 + 30);
        done_a = 1'b1; data_a = 8'h5A;
        goto(c0 + 31);
        done_a = 1'b0; data_a = 8'h00;
        at(c0 + 40);
        chk("red_value_hold", {24'b0, red_val_a}, 32'h5A);
        at(c0 + 63);
        chk("leds_before_swap", {30'b0, led_red_a, led_ir_a}, 32'b10);
        at(c0 + 64);
        chk("leds_swap", {30'b0, led_red_a, led_ir_a}, 32'b01);
        at(c0 + 74);
        chk("ir_start", {31'b0, start_a}, 32'd1);
        goto(c0 + 94);
        done_a = 1'b1; data_a = 8'hA5;
        goto(c0 + 95);
        done_a = 1'b0; data_a = 8'h00;
        at(c0 + 127);
        chk("leds_ir_end", {30'b0, led_red_a, led_ir_a}, 32'b01);
        at(c0 + 128);
        chk("period_leds", {30'b0, led_red_a, led_ir_a}, 32'b10);
        at(c0 + 138);
        chk("period_start", {31'b0, start_a}, 32'd1);

        // red conversion never answered
        at(c0 + 167);
        chk("timeout_not_yet", {31'b0, timeout_a}, 32'd0);
        at(c0 + 168);
        chk("timeout_set", {31'b0, timeout_a}, 32'd1);
        at(c0 + 190);
        chk("red_value_kept", {24'b0, red_val_a}, 32'h5A);
        qa.push_back(mk(1'b1, 8'h3C, c0 + 223));
        at(c0 + 202);
        chk("ir_start_after_timeout", {31'b0, start_a}, 32'd1);
        goto(c0 + 222);
        done_a = 1'b1; data_a = 8'h3C;
        goto(c0 + 223);
        done_a = 1'b0; data_a = 8'h00;
        at(c0 + 240);
        chk("ir_value_after_timeout", {24'b0, ir_val_a}, 32'h3C);
        chk("timeout_sticky", {31'b0, timeout_a}, 32'd1);

        // spurious done during RED_SETTLE
        goto(c0 + 258);
        done_a = 1'b1; data_a = 8'hEE;
        goto(c0 + 259);
        done_a = 1'b0; data_a = 8'h00;
        at(c0 + 262);
        chk("spurious_no_capture", {24'b0, red_val_a}, 32'h5A);
        chk("spurious_led", {30'b0, led_red_a, led_ir_a}, 32'b10);
        at(c0 + 265);
        chk("spurious_no_early_start", {31'b0, start_a}, 32'd0);
        at(c0 + 266);
        chk("spurious_start_on_time", {31'b0, start_a}, 32'd1);
        qa.push_back(mk(1'b0, 8'h11, c0 + 287));
        goto(c0 + 286);
        done_a = 1'b1; data_a = 8'h11;
        goto(c0 + 287);
        done_a = 1'b0; data_a = 8'h00;

        // enable dropped mid IR phase
        qa.push_back(mk(1'b1, 8'h77, c0 + 351));
        goto(c0 + 325);
        enable_a = 1'b0;
        at(c0 + 330);
        chk("disable_ir_start", {31'b0, start_a}, 32'd1);
        goto(c0 + 350);
        done_a = 1'b1; data_a = 8'h77;
        goto(c0 + 351);
        done_a = 1'b0; data_a = 8'h00;
        at(c0 + 383);
        chk("disable_ir_still_on", {30'b0, led_red_a, led_ir_a}, 32'b01);
        at(c0 + 384);
        chk("disable_leds_off", {30'b0, led_red_a, led_ir_a}, 32'b00);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            at(c0 + 385 + i);
            if (start_a !== 1'b0 || led_red_a !== 1'b0 || led_ir_a !== 1'b0) seen = 1'b1;
        end
        chk("disable_stays_idle", {31'b0, seen}, 32'd0);

        // reset during RED_CONV, then a stray done
        goto(c0 + 440);
        enable_a = 1'b1;
        c1 = c0 + 441;
        at(c1 + 10);
        chk("rst_test_start", {31'b0, start_a}, 32'd1);
        goto(c1 + 15);
        rst_n = 1'b0; enable_a = 1'b0;
        goto(c1 + 16);
        rst_n = 1'b1;
        at(c1 + 16);
        chk("midconv_reset_outs", {11'b0, outs_a}, 32'h0);
        goto(c1 + 18);
        done_a = 1'b1; data_a = 8'hEE;
        goto(c1 + 19);
        done_a = 1'b0; data_a = 8'h00;
        at(c1 + 19);
        chk("stray_done_ignored", {11'b0, outs_a}, 32'h0);
        at(c1 + 25);
        chk("post_reset_idle", {11'b0, outs_a}, 32'h0);

        // dut_b: done on the phase-end cycle, then abort at phase end
        goto(c1 + 30);
        enable_b = 1'b1;
        cb0 = c1 + 31;
        qb.push_back(mk(1'b0, 8'hC3, cb0 + 64));
        at(cb0 + 10);
        chk("b_start", {31'b0, start_b}, 32'd1);
        goto(cb0 + 63);
        done_b = 1'b1; data_b = 8'hC3;
        at(cb0 + 63);
        chk("b_led_before_end", {30'b0, led_red_b, led_ir_b}, 32'b10);
        goto(cb0 + 64);
        done_b = 1'b0; data_b = 8'h00;
        at(cb0 + 64);
        chk("b_led_switch", {30'b0, led_red_b, led_ir_b}, 32'b01);
        chk("b_value_at_end", {24'b0, red_val_b}, 32'hC3);
        chk("b_no_timeout", {31'b0, timeout_b}, 32'd0);
        at(cb0 + 74);
        chk("b_ir_start", {31'b0, start_b}, 32'd1);
        goto(cb0 + 100);
        enable_b = 1'b0;
        at(cb0 + 127);
        chk("b_abort_not_yet", {31'b0, timeout_b}, 32'd0);
        at(cb0 + 128);
        chk("b_abort_timeout", {31'b0, timeout_b}, 32'd1);
        chk("b_abort_leds_off", {30'b0, led_red_b, led_ir_b}, 32'b00);
        chk("b_ir_value_kept", {24'b0, ir_val_b}, 32'h00);

        at(cb0 + 140);
        chk("a_queue_drained", qa.size(), 32'd0);
        chk("b_queue_drained", qb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
